// File: rtl/pixel_frame_ctrl_pkg.sv
// Shared phase encoding and default frame timing for the pixel frame sequencer.
// Pure declarations: no latency, no backpressure.
package pixel_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } state_t;

  localparam int DEF_NUM_PIXELS    = 4;
  localparam int DEF_ADC_BITS      = 8;
  localparam int DEF_ERASE_CYCLES  = 5;
  localparam int DEF_EXPOSE_CYCLES = 255;
  localparam int DEF_READ_CYCLES   = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold max_load, never less than one.
  function automatic int ctr_width(input int max_load);
    return (max_load > 0) ? $clog2(max_load + 1) : 1;
  endfunction

endpackage

// File: rtl/pixel_frame_ctrl.sv
// Free-running frame sequencer: erase, expose, ramp convert, then one-hot pixel readout.
// Latency: outputs registered one cycle after the state decision; backpressure: none, never stalls.
module pixel_frame_ctrl
  import pixel_frame_ctrl_pkg::*;
#(
  parameter int NUM_PIXELS    = DEF_NUM_PIXELS,
  parameter int ADC_BITS      = DEF_ADC_BITS,
  parameter int ERASE_CYCLES  = DEF_ERASE_CYCLES,
  parameter int EXPOSE_CYCLES = DEF_EXPOSE_CYCLES,
  parameter int READ_CYCLES   = DEF_READ_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic                  ERASE,
  output logic                  EXPOSE,
  output logic                  CONVERT,
  output logic [ADC_BITS-1:0]   ADC_COUNT,
  output logic [NUM_PIXELS-1:0] READ_SEL,
  output logic                  FRAME_DONE,
  output logic [2:0]            STATE
);

  localparam int CW = ctr_width(max3(ERASE_CYCLES - 1, EXPOSE_CYCLES - 1, READ_CYCLES - 1));
  localparam int PW = ctr_width(NUM_PIXELS - 1);

  localparam logic [CW-1:0]         ERASE_LOAD  = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0]         EXPOSE_LOAD = CW'(EXPOSE_CYCLES - 1);
  localparam logic [CW-1:0]         READ_LOAD   = CW'(READ_CYCLES - 1);
  localparam logic [PW-1:0]         LAST_PIX    = PW'(NUM_PIXELS - 1);
  localparam logic [ADC_BITS-1:0]   ADC_MAX     = '1;
  localparam logic [NUM_PIXELS-1:0] SEL0        = NUM_PIXELS'(1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADC_BITS-1:0]     adc_q, adc_d;
  logic [PW-1:0]           pix_q, pix_d;
  logic                    erase_q, expose_q, convert_q, done_q;
  logic [NUM_PIXELS-1:0]   read_sel_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adc_d   = adc_q;
    pix_d   = pix_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_ERASE;
        cnt_d   = ERASE_LOAD;
      end
      ST_ERASE: begin
        if (cnt_q == '0) begin
          state_d = ST_EXPOSE;
          cnt_d   = EXPOSE_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_EXPOSE: begin
        if (cnt_q == '0) begin
          state_d = ST_CONVERT;
          adc_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      // The ramp code itself times the convert phase; it stops at full scale.
      ST_CONVERT: begin
        if (adc_q == ADC_MAX) begin
          state_d = ST_READ;
          adc_d   = '0;
          pix_d   = '0;
          cnt_d   = READ_LOAD;
        end else begin
          adc_d = adc_q + ADC_BITS'(1);
        end
      end
      ST_READ: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (pix_q == LAST_PIX) begin
          state_d = ST_ERASE;
          cnt_d   = ERASE_LOAD;
          pix_d   = '0;
        end else begin
          pix_d = pix_q + PW'(1);
          cnt_d = READ_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        adc_d   = '0;
        pix_d   = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      adc_q      <= '0;
      pix_q      <= '0;
      erase_q    <= 1'b0;
      expose_q   <= 1'b0;
      convert_q  <= 1'b0;
      read_sel_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adc_q      <= adc_d;
      pix_q      <= pix_d;
      erase_q    <= (state_d == ST_ERASE);
      expose_q   <= (state_d == ST_EXPOSE);
      convert_q  <= (state_d == ST_CONVERT);
      read_sel_q <= (state_d == ST_READ) ? (SEL0 << pix_d) : '0;
      done_q     <= (state_d == ST_READ) && (pix_d == LAST_PIX) && (cnt_d == '0);
    end
  end

  assign ERASE      = erase_q;
  assign EXPOSE     = expose_q;
  assign CONVERT    = convert_q;
  assign ADC_COUNT  = adc_q;
  assign READ_SEL   = read_sel_q;
  assign FRAME_DONE = done_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Checks three builds of pixel_frame_ctrl cycle by cycle against a frame-position model.
// Reset is pulsed at random points and once at ADC_COUNT=100 of the default build.
module tb_pixel_frame_ctrl;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  // Default build
  logic       a_er, a_ex, a_cv, a_fd;
  logic [7:0] a_adc;
  logic [3:0] a_sel;
  logic [2:0] a_st;
  // Single pixel, single read cycle
  logic       b_er, b_ex, b_cv, b_fd;
  logic [2:0] b_adc;
  logic [0:0] b_sel;
  logic [2:0] b_st;
  // Minimum phase lengths, four pixels, single read cycle
  logic       c_er, c_ex, c_cv, c_fd;
  logic [1:0] c_adc;
  logic [3:0] c_sel;
  logic [2:0] c_st;

  pixel_frame_ctrl dut_a (
    .CLK(CLK), .RESET(RESET), .ERASE(a_er), .EXPOSE(a_ex), .CONVERT(a_cv),
    .ADC_COUNT(a_adc), .READ_SEL(a_sel), .FRAME_DONE(a_fd), .STATE(a_st)
  );

  pixel_frame_ctrl #(
    .NUM_PIXELS(1), .ADC_BITS(3), .ERASE_CYCLES(2), .EXPOSE_CYCLES(3), .READ_CYCLES(1)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .ERASE(b_er), .EXPOSE(b_ex), .CONVERT(b_cv),
    .ADC_COUNT(b_adc), .READ_SEL(b_sel), .FRAME_DONE(b_fd), .STATE(b_st)
  );

  pixel_frame_ctrl #(
    .NUM_PIXELS(4), .ADC_BITS(2), .ERASE_CYCLES(1), .EXPOSE_CYCLES(1), .READ_CYCLES(1)
  ) dut_c (
    .CLK(CLK), .RESET(RESET), .ERASE(c_er), .EXPOSE(c_ex), .CONVERT(c_cv),
    .ADC_COUNT(c_adc), .READ_SEL(c_sel), .FRAME_DONE(c_fd), .STATE(c_st)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       er;
    logic       ex;
    logic       cv;
    logic [7:0] adc;
    logic [3:0] sel;
    logic       fd;
  } exp_t;

  int checks   = 0;
  int failures = 0;
  int pos      = 0;   // cycles since the last reset edge; 0 means IDLE
  bit pos_vld  = 0;
  int cyc      = 0;
  int last_done = 0;
  bit have_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs from the position within the repeating frame.
  function automatic exp_t model(input int p, input int np, input int ab,
                                 input int ec, input int xc, input int rc);
    exp_t e;
    int   a, len, f, r;
    e   = '0;
    a   = 1 << ab;
    len = ec + xc + a + np * rc;
    if (p == 0) return e;
    f = (p - 1) % len;
    if (f < ec) begin
      e.st = 3'd1; e.er = 1'b1;
    end else if (f < ec + xc) begin
      e.st = 3'd2; e.ex = 1'b1;
    end else if (f < ec + xc + a) begin
      e.st = 3'd3; e.cv = 1'b1; e.adc = 8'(f - ec - xc);
    end else begin
      r     = f - ec - xc - a;
      e.st  = 3'd4;
      e.sel = 4'(1 << (r / rc));
      e.fd  = (r == np * rc - 1);
    end
    return e;
  endfunction

  task automatic check_inst(input string n, input int np, input int ab, input int ec,
                            input int xc, input int rc, input logic [2:0] st,
                            input logic er, input logic ex, input logic cv,
                            input logic [7:0] adc, input logic [3:0] sel, input logic fd);
    exp_t e;
    e = model(pos, np, ab, ec, xc, rc);
    chk({n, "_state"},      32'(st),  32'(e.st));
    chk({n, "_erase"},      32'(er),  32'(e.er));
    chk({n, "_expose"},     32'(ex),  32'(e.ex));
    chk({n, "_convert"},    32'(cv),  32'(e.cv));
    chk({n, "_adc"},        32'(adc), 32'(e.adc));
    chk({n, "_read_sel"},   32'(sel), 32'(e.sel));
    chk({n, "_frame_done"}, 32'(fd),  32'(e.fd));
    chk({n, "_onehot0"},    32'($onehot0(sel)), 32'd1);
    chk({n, "_exclusive"},  32'((32'(er) + 32'(ex) + 32'(cv) + 32'(sel != 4'd0)) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge CLK);
    if (RESET) begin
      pos       = 0;
      pos_vld   = 1;
      have_done = 0;
    end else if (pos_vld) begin
      pos++;
    end
    cyc++;
    @(negedge CLK);
    if (pos_vld) begin
      check_inst("a", 4, 8, 5, 255, 2, a_st, a_er, a_ex, a_cv, a_adc, a_sel, a_fd);
      check_inst("b", 1, 3, 2, 3, 1, b_st, b_er, b_ex, b_cv, {5'd0, b_adc}, {3'd0, b_sel}, b_fd);
      check_inst("c", 4, 2, 1, 1, 1, c_st, c_er, c_ex, c_cv, {6'd0, c_adc}, c_sel, c_fd);
      if (a_fd) begin
        if (have_done) chk("a_done_period", 32'(cyc - last_done), 32'd524);
        last_done = cyc;
        have_done = 1;
      end
    end
  endtask

  initial begin
    exp_t e;
    int   n;
    RESET = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
    repeat (3 * 524 + 20) step();

    // Reset landing in the middle of the ramp
    n = 0;
    e = model(pos, 4, 8, 5, 255, 2);
    while (!(e.cv && e.adc == 8'd100) && n < 2000) begin
      step();
      e = model(pos, 4, 8, 5, 255, 2);
      n++;
    end
    chk("a_adc100_reached", 32'(n < 2000), 32'd1);
    chk("a_adc100_value", 32'(a_adc), 32'd100);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    repeat (600) step();

    for (int k = 0; k < 6; k++) begin
      RESET = 1'b0;
      repeat ($urandom_range(20, 1200)) step();
      RESET = 1'b1;
      repeat ($urandom_range(1, 3)) step();
    end
    RESET = 1'b0;
    repeat (1100) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
